// File: rtl/prog_loader_pkg.sv
// Shared constants and state encoding for the instruction-store loader.
package prog_loader_pkg;

    localparam int INST_W = 9;
    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1024;

    typedef logic [ADDR_W:0]   cnt_t;
    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [INST_W-1:0] inst_t;

    localparam cnt_t DEPTH_C = cnt_t'(DEPTH);
    localparam cnt_t ONE_C   = cnt_t'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } loader_state_t;

endpackage

// File: rtl/prog_loader_if.sv
// Stream input and instruction-memory write port seen by the loader.
interface prog_loader_if;
    import prog_loader_pkg::*;

    logic  s_valid;
    inst_t s_data;
    logic  s_ready;
    logic  wr_en;
    addr_t wr_addr;
    inst_t wr_data;

    modport slave (
        input  s_valid, s_data,
        output s_ready, wr_en, wr_addr, wr_data
    );

    modport master (
        output s_valid, s_data,
        input  s_ready, wr_en, wr_addr, wr_data
    );

endinterface

// File: rtl/prog_loader.sv
// Streams instruction words into memory from address 0 and holds
// the fetch unit at PC 0 until the image is complete.
module prog_loader
    import prog_loader_pkg::*;
(
    input  logic          CLK,
    input  logic          start,
    input  logic          load_req,
    input  cnt_t          load_len,
    input  logic          abort,
    prog_loader_if.slave  bus,
    output logic          core_start,
    output logic          busy,
    output logic          done,
    output logic          err
);

    loader_state_t state_q;
    cnt_t          count_q;
    cnt_t          len_q;
    logic          wr_en_q;
    addr_t         wr_addr_q;
    inst_t         wr_data_q;
    logic          core_start_q;
    logic          done_q;
    logic          err_q;

    logic hs;
    logic last;
    logic bad_len;

    assign bus.s_ready = (state_q == LOAD);
    assign busy        = (state_q != IDLE);
    assign hs          = bus.s_valid & bus.s_ready;
    assign last        = (count_q == len_q - ONE_C);
    assign bad_len     = (load_len == '0) || (load_len > DEPTH_C);

    always_ff @(posedge CLK or posedge start) begin
        if (start) begin
            state_q      <= IDLE;
            count_q      <= '0;
            len_q        <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            core_start_q <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            wr_en_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (load_req) begin
                        if (bad_len) begin
                            err_q <= 1'b1;
                        end else begin
                            len_q        <= load_len;
                            count_q      <= '0;
                            core_start_q <= 1'b1;
                            state_q      <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    // abort wins over a handshake in the same cycle
                    if (abort) begin
                        err_q        <= 1'b1;
                        core_start_q <= 1'b0;
                        state_q      <= IDLE;
                    end else if (hs) begin
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= count_q[ADDR_W-1:0];
                        wr_data_q <= bus.s_data;
                        count_q   <= count_q + ONE_C;
                        if (last) begin
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    core_start_q <= 1'b0;
                    state_q      <= IDLE;
                end
                default: begin
                    core_start_q <= 1'b0;
                    state_q      <= IDLE;
                end
            endcase
        end
    end

    assign bus.wr_en   = wr_en_q;
    assign bus.wr_addr = wr_addr_q;
    assign bus.wr_data = wr_data_q;
    assign core_start  = core_start_q;
    assign done        = done_q;
    assign err         = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: writes, gaps, bad lengths,
// abort, full-depth image and mid-load reset.
module tb_prog_loader;
    import prog_loader_pkg::*;

    logic CLK;
    logic start;
    logic load_req;
    cnt_t load_len;
    logic abort;
    logic core_start;
    logic busy;
    logic done;
    logic err;

    prog_loader_if bus ();

    prog_loader dut (
        .CLK        (CLK),
        .start      (start),
        .load_req   (load_req),
        .load_len   (load_len),
        .abort      (abort),
        .bus        (bus.slave),
        .core_start (core_start),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_chk;
    int n_err;

    int    wa[$];
    int    wd[$];
    int    done_cnt;
    int    err_cnt;
    int    both_cnt;

    always @(negedge CLK) begin
        if (bus.wr_en) begin
            wa.push_back(int'(bus.wr_addr));
            wd.push_back(int'(bus.wr_data));
        end
        if (done) done_cnt++;
        if (err) err_cnt++;
        if (done && err) both_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clr_log();
        wa.delete();
        wd.delete();
        done_cnt = 0;
        err_cnt  = 0;
    endtask

    task automatic req(input int len);
        load_req = 1'b1;
        load_len = cnt_t'(len);
        tick();
        load_req = 1'b0;
    endtask

    task automatic send(input int data, input int gap);
        bus.s_valid = 1'b1;
        bus.s_data  = inst_t'(data);
        tick();
        bus.s_valid = 1'b0;
        repeat (gap) tick();
    endtask

    int bad;
    int zero_wr;

    initial begin
        n_chk = 0;
        n_err = 0;
        both_cnt = 0;
        start = 1'b1;
        load_req = 1'b0;
        load_len = '0;
        abort = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_data = '0;
        clr_log();
        repeat (2) tick();
        chk("rst_wr_en", 32'(bus.wr_en), 0);
        chk("rst_addr", 32'(bus.wr_addr), 0);
        chk("rst_cs", 32'(core_start), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ready", 32'(bus.s_ready), 0);
        start = 1'b0;
        tick();

        // 1: three words back to back
        clr_log();
        req(3);
        chk("t1_cs_load", 32'(core_start), 1);
        chk("t1_ready", 32'(bus.s_ready), 1);
        bus.s_valid = 1'b1;
        bus.s_data = 9'h101;
        tick();
        chk("t1_w0", {bus.wr_en, 6'd0, bus.wr_addr, 6'd0, bus.wr_data},
            {1'b1, 6'd0, 10'd0, 6'd0, 9'h101});
        bus.s_data = 9'h0A2;
        tick();
        chk("t1_w1", {bus.wr_en, 6'd0, bus.wr_addr, 6'd0, bus.wr_data},
            {1'b1, 6'd0, 10'd1, 6'd0, 9'h0A2});
        bus.s_data = 9'h1FF;
        tick();
        bus.s_valid = 1'b0;
        chk("t1_w2", {bus.wr_en, 6'd0, bus.wr_addr, 6'd0, bus.wr_data},
            {1'b1, 6'd0, 10'd2, 6'd0, 9'h1FF});
        chk("t1_done", {29'd0, done, core_start, bus.s_ready}, 32'b110);
        tick();
        chk("t1_after", {28'd0, done, core_start, busy, bus.wr_en}, 0);
        chk("t1_nwr", 32'(wa.size()), 3);
        chk("t1_ndone", 32'(done_cnt), 1);

        // 2: four words with two idle cycles between
        clr_log();
        req(4);
        for (int i = 0; i < 4; i++) send(16 + i, 2);
        chk("t2_nwr", 32'(wa.size()), 4);
        bad = 0;
        for (int i = 0; i < wa.size() && i < 4; i++)
            if (wa[i] != i || wd[i] != 16 + i) bad++;
        chk("t2_order", 32'(bad), 0);
        chk("t2_ndone", 32'(done_cnt), 1);
        chk("t2_idle", 32'(busy), 0);

        // 3: rejected lengths
        clr_log();
        req(0);
        chk("t3_err0", {30'd0, err, busy}, 32'b10);
        tick();
        chk("t3_err0_off", 32'(err), 0);
        req(1025);
        chk("t3_err1025", {30'd0, err, busy}, 32'b10);
        tick();
        chk("t3_nerr", 32'(err_cnt), 2);
        chk("t3_nwr", 32'(wa.size()), 0);

        // 4: abort after three words, fourth word offered in same cycle
        clr_log();
        req(8);
        for (int i = 0; i < 3; i++) send(32 + i, 0);
        bus.s_valid = 1'b1;
        bus.s_data = 9'h1AA;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        bus.s_valid = 1'b0;
        chk("t4_abort", {27'd0, err, done, core_start, busy, bus.wr_en},
            32'b10000);
        tick();
        chk("t4_nwr", 32'(wa.size()), 3);
        chk("t4_last", 32'(wa[wa.size()-1]), 2);
        chk("t4_ndone", 32'(done_cnt), 0);
        clr_log();
        req(1);
        send(9'h055, 0);
        chk("t4_reload", {done, 6'd0, bus.wr_addr, 6'd0, bus.wr_data},
            {1'b1, 6'd0, 10'd0, 6'd0, 9'h055});
        tick();

        // 5: full-depth image
        clr_log();
        req(DEPTH);
        bus.s_valid = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            bus.s_data = inst_t'(i);
            tick();
        end
        bus.s_valid = 1'b0;
        chk("t5_last", {done, 6'd0, bus.wr_addr, 6'd0, bus.wr_data},
            {1'b1, 6'd0, 10'd1023, 6'd0, 9'h1FF});
        tick();
        chk("t5_nwr", 32'(wa.size()), 1024);
        bad = 0;
        zero_wr = 0;
        for (int i = 0; i < wa.size(); i++) begin
            if (wa[i] != i || wd[i] != (i & 511)) bad++;
            if (wa[i] == 0) zero_wr++;
        end
        chk("t5_data", 32'(bad), 0);
        chk("t5_addr0", 32'(zero_wr), 1);

        // 6: reset in the middle of a load
        clr_log();
        req(8);
        for (int i = 0; i < 5; i++) send(64 + i, 0);
        chk("t6_pre", 32'(bus.wr_en), 1);
        #2;
        start = 1'b1;
        #1;
        chk("t6_async", {26'd0, err, done, core_start, busy, bus.wr_en,
                         bus.s_ready}, 0);
        chk("t6_addr", 32'(bus.wr_addr), 0);
        tick();
        start = 1'b0;
        tick();
        chk("t6_pulses", 32'(done_cnt + err_cnt), 0);
        clr_log();
        req(2);
        send(9'h0C3, 0);
        send(9'h13C, 0);
        tick();
        chk("t6_restart", 32'(wa.size() == 2 && wa[0] == 0 && wa[1] == 1),
            1);
        chk("t6_ndone", 32'(done_cnt), 1);

        chk("never_both", 32'(both_cnt), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
